// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with fill count, almost-full/empty thresholds,
// registered read data with valid strobe, and overflow/underflow error pulses.
module fifo_sync_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             rd_ok;
    logic             wr_ok;

    // Explicit wrap so non-power-of-2 depths never index past the array.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Flags decode the registered count only.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    // A read at full frees the slot the write lands in, so both are accepted.
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_ok)
                wp <= ptr_inc(wp);
            if (rd_ok) begin
                rp   <= ptr_inc(rp);
                dout <= mem[rp];
            end
            dout_valid <= rd_ok;
            overflow   <= wr_en & ~wr_ok;
            underflow  <= rd_en & ~rd_ok;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not cleared by reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok)
            mem[wp] <= din;
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param: default 16x8 instance plus
// a 5x12 instance for non-power-of-2 pointer wrap.
module tb_fifo_sync_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic [7:0] a_din = '0;
    logic       a_wr = 1'b0, a_rd = 1'b0;
    logic [7:0] a_dout;
    logic       a_dv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [4:0] a_count;

    // depth-5 instance
    logic [11:0] b_din = '0;
    logic        b_wr = 1'b0, b_rd = 1'b0;
    logic [11:0] b_dout;
    logic        b_dv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0]  b_count;

    int n_chk  = 0;
    int n_pass = 0;

    fifo_sync_param dut_a (
        .clk(clk), .rst(rst), .din(a_din), .wr_en(a_wr), .rd_en(a_rd),
        .dout(a_dout), .dout_valid(a_dv), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_unf)
    );

    fifo_sync_param #(.WIDTH(12), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) dut_b (
        .clk(clk), .rst(rst), .din(b_din), .wr_en(b_wr), .rd_en(b_rd),
        .dout(b_dout), .dout_valid(b_dv), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_a();
        for (int i = 1; i <= 16; i++) begin
            a_din = 8'(i);
            a_wr  = 1'b1;
            step();
        end
        a_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_chk++;
        if ({a_empty, a_full, a_ae, a_af} !== 4'b1010)
            $display("FAIL reset_flags: got %b want 1010", {a_empty, a_full, a_ae, a_af});
        else n_pass++;
        n_chk++;
        if (a_count !== 5'd0 || a_dout !== 8'h00)
            $display("FAIL reset_count_dout: got count=%0d dout=%h want 0/00", a_count, a_dout);
        else n_pass++;
        n_chk++;
        if ({a_dv, a_ovf, a_unf} !== 3'b000)
            $display("FAIL reset_pulses: got %b want 000", {a_dv, a_ovf, a_unf});
        else n_pass++;
        n_chk++;
        if (b_empty !== 1'b1 || b_count !== 3'd0)
            $display("FAIL reset_b: got empty=%b count=%0d want 1/0", b_empty, b_count);
        else n_pass++;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            a_din = 8'(i);
            a_wr  = 1'b1;
            step();
            n_chk++;
            if (a_count !== 5'(i) || a_full !== (i == 16) || a_af !== (i >= 14) ||
                a_ae !== (i <= 2) || a_empty !== 1'b0)
                $display("FAIL fill_%0d: got count=%0d full=%b af=%b ae=%b empty=%b",
                         i, a_count, a_full, a_af, a_ae, a_empty);
            else n_pass++;
        end
        a_wr = 1'b0;
        a_rd = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            n_chk++;
            if (a_dout !== 8'(i) || a_dv !== 1'b1 || a_count !== 5'(16 - i))
                $display("FAIL drain_%0d: got dout=%h dv=%b count=%0d want %h/1/%0d",
                         i, a_dout, a_dv, a_count, 8'(i), 16 - i);
            else n_pass++;
        end
        a_rd = 1'b0;
        step();
        n_chk++;
        if (a_empty !== 1'b1 || a_dv !== 1'b0)
            $display("FAIL drain_end: got empty=%b dv=%b want 1/0", a_empty, a_dv);
        else n_pass++;
    endtask

    task automatic test_overflow();
        fill_a();
        a_din = 8'hAA;
        a_wr  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_chk++;
            if (a_ovf !== 1'b1 || a_count !== 5'd16)
                $display("FAIL overflow_%0d: got ovf=%b count=%0d want 1/16", k, a_ovf, a_count);
            else n_pass++;
        end
        a_wr = 1'b0;
        a_rd = 1'b1;
        step();
        n_chk++;
        if (a_ovf !== 1'b0)
            $display("FAIL overflow_end: got ovf=%b want 0", a_ovf);
        else n_pass++;
        for (int i = 1; i <= 16; i++) begin
            if (i > 1) step();
            n_chk++;
            if (a_dout !== 8'(i) || a_dv !== 1'b1)
                $display("FAIL overflow_drain_%0d: got dout=%h dv=%b want %h/1", i, a_dout, a_dv, 8'(i));
            else n_pass++;
        end
        a_rd = 1'b0;
        step();
        n_chk++;
        if (a_empty !== 1'b1)
            $display("FAIL overflow_empty: got empty=%b want 1", a_empty);
        else n_pass++;
    endtask

    task automatic test_empty_simul();
        a_din = 8'h55;
        a_wr  = 1'b1;
        a_rd  = 1'b1;
        step();
        n_chk++;
        if (a_unf !== 1'b1 || a_dv !== 1'b0 || a_count !== 5'd1)
            $display("FAIL empty_simul: got unf=%b dv=%b count=%0d want 1/0/1", a_unf, a_dv, a_count);
        else n_pass++;
        a_wr = 1'b0;
        step();
        n_chk++;
        if (a_dout !== 8'h55 || a_dv !== 1'b1 || a_unf !== 1'b0 || a_count !== 5'd0)
            $display("FAIL empty_simul_read: got dout=%h dv=%b unf=%b count=%0d want 55/1/0/0",
                     a_dout, a_dv, a_unf, a_count);
        else n_pass++;
        a_rd = 1'b0;
        step();
    endtask

    task automatic test_full_simul();
        fill_a();
        a_din = 8'h99;
        a_wr  = 1'b1;
        a_rd  = 1'b1;
        step();
        n_chk++;
        if (a_dout !== 8'h01 || a_dv !== 1'b1 || a_count !== 5'd16 || a_ovf !== 1'b0)
            $display("FAIL full_simul: got dout=%h dv=%b count=%0d ovf=%b want 01/1/16/0",
                     a_dout, a_dv, a_count, a_ovf);
        else n_pass++;
        a_wr = 1'b0;
        for (int i = 2; i <= 17; i++) begin
            step();
            n_chk++;
            if (a_dout !== ((i == 17) ? 8'h99 : 8'(i)) || a_dv !== 1'b1)
                $display("FAIL full_simul_drain_%0d: got dout=%h dv=%b want %h/1",
                         i, a_dout, a_dv, (i == 17) ? 8'h99 : 8'(i));
            else n_pass++;
        end
        a_rd = 1'b0;
        step();
        n_chk++;
        if (a_empty !== 1'b1)
            $display("FAIL full_simul_empty: got empty=%b want 1", a_empty);
        else n_pass++;
    endtask

    // Preload 2, then 13 simultaneous write/read pairs, then drain: 15 writes
    // through a 5-entry ring gives three pointer wraps.
    task automatic test_wrap();
        for (int k = 0; k < 2; k++) begin
            b_din = 12'h100 + 12'(k);
            b_wr  = 1'b1;
            step();
        end
        n_chk++;
        if (b_count !== 3'd2 || b_ae !== 1'b0)
            $display("FAIL wrap_preload: got count=%0d ae=%b want 2/0", b_count, b_ae);
        else n_pass++;
        b_rd = 1'b1;
        for (int j = 0; j < 13; j++) begin
            b_din = 12'h102 + 12'(j);
            step();
            n_chk++;
            if (b_dout !== 12'h100 + 12'(j) || b_dv !== 1'b1 || b_count !== 3'd2)
                $display("FAIL wrap_%0d: got dout=%h dv=%b count=%0d want %h/1/2",
                         j, b_dout, b_dv, b_count, 12'h100 + 12'(j));
            else n_pass++;
        end
        b_wr = 1'b0;
        for (int j = 13; j < 15; j++) begin
            step();
            n_chk++;
            if (b_dout !== 12'h100 + 12'(j) || b_dv !== 1'b1)
                $display("FAIL wrap_drain_%0d: got dout=%h want %h", j, b_dout, 12'h100 + 12'(j));
            else n_pass++;
        end
        b_rd = 1'b0;
        // fill the 5-deep instance to its boundary
        for (int k = 0; k < 6; k++) begin
            b_din = 12'hA00 + 12'(k);
            b_wr  = 1'b1;
            step();
        end
        b_wr = 1'b0;
        n_chk++;
        if (b_count !== 3'd5 || b_full !== 1'b1 || b_af !== 1'b1 || b_ovf !== 1'b1)
            $display("FAIL wrap_full: got count=%0d full=%b af=%b ovf=%b want 5/1/1/1",
                     b_count, b_full, b_af, b_ovf);
        else n_pass++;
        b_rd = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_chk++;
            if (b_dout !== 12'hA00 + 12'(k))
                $display("FAIL wrap_full_drain_%0d: got %h want %h", k, b_dout, 12'hA00 + 12'(k));
            else n_pass++;
        end
        b_rd = 1'b0;
        step();
    endtask

    task automatic test_mid_reset();
        a_rd = 1'b0;
        a_wr = 1'b1;
        a_din = 8'h11; step();
        a_din = 8'h22; step();
        a_rd  = 1'b1;                  // read one so dout is nonzero before reset
        a_din = 8'h33; step();
        a_rd  = 1'b0;
        n_chk++;
        if (a_count !== 5'd2 || a_dout !== 8'h11)
            $display("FAIL mid_pre: got count=%0d dout=%h want 2/11", a_count, a_dout);
        else n_pass++;
        rst   = 1'b1;
        a_din = 8'h44;
        step();
        rst  = 1'b0;
        a_wr = 1'b0;
        n_chk++;
        if (a_count !== 5'd0 || a_dout !== 8'h00 || {a_empty, a_full, a_ae, a_af} !== 4'b1010 ||
            {a_dv, a_ovf, a_unf} !== 3'b000)
            $display("FAIL mid_reset: got count=%0d dout=%h flags=%b pulses=%b",
                     a_count, a_dout, {a_empty, a_full, a_ae, a_af}, {a_dv, a_ovf, a_unf});
        else n_pass++;
        a_din = 8'h7E;
        a_wr  = 1'b1;
        step();
        a_wr = 1'b0;
        a_rd = 1'b1;
        step();
        a_rd = 1'b0;
        n_chk++;
        if (a_dout !== 8'h7E || a_dv !== 1'b1 || a_count !== 5'd0)
            $display("FAIL mid_post: got dout=%h dv=%b count=%0d want 7E/1/0", a_dout, a_dv, a_count);
        else n_pass++;
    endtask

    initial begin
        #1;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_empty_simul();
        test_full_simul();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
